clkdiv_multi: RTL



---
 rtl/clkdiv_multi.sv | 78 +++++++
 1 files changed

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel programmable tick / square-wave divider
// Optional macro CLKDIV_SYNC_EN adds a global sync input that phase-aligns all channels.
module clkdiv_multi #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 22,
  parameter int DEF_DIV = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic [NCH-1:0]   en,
  input  logic             div_wr,
  input  logic [3:0]       div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq,
  output logic [CNT_W-1:0] cnt_dbg
);

  logic [CNT_W-1:0] cnt [NCH];
  logic [CNT_W-1:0] div [NCH];
  logic [NCH-1:0]   wr_hit;

  // Selects >= NCH match no channel, so such writes fall through harmlessly.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = div_wr && (div_sel == 4'(i));
    end
  end

  always_comb begin
    cnt_dbg = '0;
    for (int i = 0; i < NCH; i++) begin
      if (div_sel == 4'(i)) cnt_dbg = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        div[i] <= CNT_W'(DEF_DIV);
      end
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
`ifdef CLKDIV_SYNC_EN
        if (sync) begin
          if (wr_hit[i]) div[i] <= div_val;
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          sq[i]   <= 1'b0;
        end else
`endif
        if (wr_hit[i]) begin
          div[i]  <= div_val;
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (!en[i]) begin
          tick[i] <= 1'b0;
        end else if (cnt[i] >= div[i]) begin
          // >= so a counter left above a freshly shrunk divisor terminates at once.
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          sq[i]   <= ~sq[i];
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule
